// File: rtl/ksa_word_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ksa_word_sequencer_pkg
// Shared definitions for the byte-serial wide adder/subtractor sequencer.
//   BYTE_W    : width of one slice handled by the external 8-bit core
//   state_t   : sequencer state encoding (2'd3 is unused and recovers to IDLE)
//   idx_width : width of the byte index counter for a given slice count
// ---------------------------------------------------------------------------
package ksa_word_sequencer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Never narrower than one bit so a 2-slice build still has a counter.
    function automatic int idx_width(input int nbytes);
        return (nbytes <= 2) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/ksa_word_sequencer_slice_mux.sv
// ---------------------------------------------------------------------------
// ksa_word_sequencer_slice_mux
// Selects byte idx of the captured A and B words for the 8-bit core.
// Outputs are forced to zero when en is low so the core sees a quiet bus
// outside the RUN state.
//   a_word, b_word : captured operand words (B already conditioned for SUB)
//   idx            : byte index, 0 = least significant byte
//   en             : high while the sequencer is in RUN
//   slice_a/b      : selected bytes
// ---------------------------------------------------------------------------
module ksa_word_sequencer_slice_mux
    import ksa_word_sequencer_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int IDX_W  = 2
) (
    input  logic [BYTE_W*NBYTES-1:0] a_word,
    input  logic [BYTE_W*NBYTES-1:0] b_word,
    input  logic [IDX_W-1:0]         idx,
    input  logic                     en,
    output logic [BYTE_W-1:0]        slice_a,
    output logic [BYTE_W-1:0]        slice_b
);

    logic [BYTE_W-1:0] a_bytes [NBYTES];
    logic [BYTE_W-1:0] b_bytes [NBYTES];

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_split
            assign a_bytes[gi] = a_word[gi*BYTE_W +: BYTE_W];
            assign b_bytes[gi] = b_word[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        // Guard keeps non-power-of-two slice counts from reading past the end.
        if (en && (int'(idx) < NBYTES)) begin
            slice_a = a_bytes[idx];
            slice_b = b_bytes[idx];
        end
    end

endmodule

// File: rtl/ksa_word_sequencer.sv
// ---------------------------------------------------------------------------
// ksa_word_sequencer
// Multi-cycle wide adder/subtractor. One WIDTH-bit operand pair is accepted
// per transaction and streamed LSB byte first through an external 8-bit
// lookahead adder core, chaining the carry from cycle to cycle. The full
// result, carry-out and signed overflow are held on a valid/ready output.
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake (A, B, SUB, in_C)
//   ADD_A/ADD_B/ADD_CIN : inputs of the external 8-bit core (0 outside RUN)
//   ADD_S/ADD_COUT      : combinational sum/carry returned by the core
//   out_valid/out_ready : result handshake (S, out_C, OVF)
// ---------------------------------------------------------------------------
module ksa_word_sequencer
    import ksa_word_sequencer_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] A,
    input  logic [BYTE_W*NBYTES-1:0] B,
    input  logic                     SUB,
    input  logic                     in_C,
    output logic [BYTE_W-1:0]        ADD_A,
    output logic [BYTE_W-1:0]        ADD_B,
    output logic                     ADD_CIN,
    input  logic [BYTE_W-1:0]        ADD_S,
    input  logic                     ADD_COUT,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] S,
    output logic                     out_C,
    output logic                     OVF
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t           state_reg, state_next;
    logic [W-1:0]     a_reg, a_next;
    logic [W-1:0]     b_reg, b_next;
    logic [W-1:0]     s_reg, s_next;
    logic             carry_reg, carry_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             out_c_reg, out_c_next;
    logic             ovf_reg, ovf_next;
    logic             run_active;

    assign run_active = (state_reg == RUN);

    // ------------------------------------------------------------------
    // Byte select towards the core
    // ------------------------------------------------------------------
    ksa_word_sequencer_slice_mux #(
        .NBYTES (NBYTES),
        .IDX_W  (IDX_W)
    ) u_slice_mux (
        .a_word  (a_reg),
        .b_word  (b_reg),
        .idx     (idx_reg),
        .en      (run_active),
        .slice_a (ADD_A),
        .slice_b (ADD_B)
    );

    assign ADD_CIN = run_active & carry_reg;

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            out_c_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            s_reg     <= s_next;
            carry_reg <= carry_next;
            idx_reg   <= idx_next;
            out_c_reg <= out_c_next;
            ovf_reg   <= ovf_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        s_next     = s_reg;
        carry_next = carry_reg;
        idx_next   = idx_reg;
        out_c_next = out_c_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next     = A;
                    // Subtraction is A + ~B + 1, so B is inverted once here
                    // and the +1 rides in as the initial carry.
                    b_next     = SUB ? ~B : B;
                    carry_next = SUB ? 1'b1 : in_C;
                    idx_next   = '0;
                    state_next = RUN;
                end
            end

            RUN: begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx_reg == IDX_W'(i)) begin
                        s_next[i*BYTE_W +: BYTE_W] = ADD_S;
                    end
                end
                carry_next = ADD_COUT;
                if (idx_reg == LAST_IDX) begin
                    out_c_next = ADD_COUT;
                    // b_reg holds the effective addend, so its sign bit is the
                    // right one to compare for both add and subtract.
                    ovf_next   = (a_reg[W-1] == b_reg[W-1]) &&
                                 (ADD_S[BYTE_W-1] != a_reg[W-1]);
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // in_ready is also qualified by rst_n so it is low for the whole reset.
    assign in_ready  = (state_reg == IDLE) && rst_n;
    assign out_valid = (state_reg == DONE);
    assign S         = s_reg;
    assign out_C     = out_c_reg;
    assign OVF       = ovf_reg;

endmodule

// File: doc/ksa_word_sequencer.md
Name: ksa_word_sequencer

Overview:
- Multi-cycle wide adder/subtractor built around the team's existing 8-bit lookahead adder core.
- Accepts one WIDTH-bit operand pair per transaction on a valid/ready handshake.
- Streams the operands byte by byte into the 8-bit core, least significant byte first, chaining the carry across cycles.
- Collects the byte sums and presents the full-width result, carry and signed overflow on a valid/ready output.
- Sits directly upstream and downstream of the 8-bit core: it drives the core's inputs and consumes its sum and carry-out. The core is instantiated by the parent, not inside this block.

Parameters:
NBYTES, 4, number of 8-bit slices; operand width = 8*NBYTES (legal 2..16)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
A  input  8*NBYTES  operand A
B  input  8*NBYTES  operand B
SUB  input  1  1 = A-B, 0 = A+B
in_C  input  1  carry-in for add (ignored when SUB=1)
ADD_A  output  8  byte slice of A to the 8-bit core
ADD_B  output  8  byte slice of B-operand to the core
ADD_CIN  output  1  carry to the core
ADD_S  input  8  core sum (combinational, same cycle)
ADD_COUT  input  1  core carry-out (combinational, same cycle)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
S  output  8*NBYTES  result
out_C  output  1  final carry-out (for SUB: 1 = no borrow)
OVF  output  1  signed overflow

Behaviour:
Reset:
- rst_n low asynchronously sets state IDLE, all registers 0, S=0, out_C=0, OVF=0, out_valid=0.
- in_ready=0 while rst_n is low.
- ADD_A, ADD_B and ADD_CIN drive 0 outside RUN.

States:
- IDLE: in_ready=1. On in_valid&in_ready:
  - capture A_reg=A.
  - capture B_reg=SUB ? ~B : B.
  - capture carry_reg=SUB ? 1 : in_C.
  - clear idx and go to RUN.
- RUN: in_ready=0.
  - ADD_A=A_reg[8*idx+:8], ADD_B=B_reg[8*idx+:8], ADD_CIN=carry_reg.
  - Each edge: S_reg[8*idx+:8]<=ADD_S, carry_reg<=ADD_COUT, idx<=idx+1.
  - When idx==NBYTES-1: after the capture, out_C<=ADD_COUT and OVF<=(A_reg[MSB]==B_reg[MSB]) && (ADD_S[7]!=A_reg[MSB]). Then go to DONE.
  - idx never wraps within RUN.
- DONE: out_valid=1. S, out_C and OVF are stable and held unchanged while out_ready=0.
  - On out_ready go to IDLE; out_valid drops the next cycle.
  - S, out_C and OVF keep their last values until overwritten.

Timing:
- Latency from the accept edge to the first out_valid cycle is NBYTES edges.
- Minimum throughput is one transaction per NBYTES+2 cycles.
- No overlap: in_ready is low in RUN and DONE, and in_valid is ignored there.
- A and B are sampled only on the accept edge; later input changes have no effect.

Arithmetic:
- Modulo 2^(8*NBYTES).
- SUB uses two's complement (~B plus carry 1); in_C does not participate in SUB.

Reset mid-operation: the transaction is discarded, no out_valid is produced, and the block returns to IDLE.

Core contract: ADD_S and ADD_COUT must settle within the same cycle. The parent guarantees the combinational path core→block→core meets timing.

Decomposition:
- Shared package:
  - BYTE_W=8.
  - State encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - idx width = clog2(NBYTES).
- No mandatory sub-module. Natural optional split: ksa_slice_mux, the byte-select of A_reg/B_reg by idx. Result byte write-back stays in the top level.
- Bench instantiates the 8-bit core and connects the ADD_* ports.

Test Plan:
1. NBYTES=4, SUB=0, in_C=0, A=0x000000FF, B=0x00000001 → after 4 edges: S=0x00000100, out_C=0, OVF=0; carry seen on ADD_CIN in cycle idx=1 only.
2. A=0xFFFFFFFF, B=0x00000001, in_C=0 → S=0x00000000, out_C=1, OVF=0. A=0x7FFFFFFF, B=0x00000001 → S=0x80000000, out_C=0, OVF=1.
3. SUB=1, A=0x00000005, B=0x00000007, in_C=1 (ignored) → S=0xFFFFFFFE, out_C=0, OVF=0. SUB=1, A=0x80000000, B=1 → S=0x7FFFFFFF, out_C=1, OVF=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid → S, out_C and OVF unchanged, in_ready=0. in_valid pulsed with new operands during RUN and DONE is ignored, and the result is unchanged.
5. Back-to-back: in_valid held high with out_ready=1 → accepts spaced exactly NBYTES+2 cycles apart. SUB=0, in_C=1, A=B=0x12345678 → S=0x2468ACF1.
6. Assert rst_n low at idx=2 of RUN → all outputs 0 asynchronously, no out_valid after release. The next transaction (0x1+0x1) gives S=0x00000002.
